// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    // Access size encoding as presented on the request channel; 2'b11 is illegal.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Natural alignment check on the low address bits. The illegal size code
    // is not flagged here; the caller reports it separately.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic w_bad;
        case (size)
            SZ_HALF: w_bad = addr_lo[0];
            SZ_WORD: w_bad = (addr_lo != 2'b00);
            default: w_bad = 1'b0;
        endcase
        return w_bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word: extracts load data from
// the selected lane(s) and builds the merged word for sub-word stores.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword out of the old word.
    always_comb begin
        w_byte = i_old_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_old_word[7:0];
            2'd1:    w_byte = i_old_word[15:8];
            2'd2:    w_byte = i_old_word[23:16];
            default: w_byte = i_old_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];
    end

    // Right-align the selected lane and zero- or sign-extend it.
    always_comb begin
        o_load_data = i_old_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load_data = i_old_word;
        endcase
    end

    // Replace only the addressed lane(s); a word store takes the data whole.
    always_comb begin
        o_merged_word = i_old_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'd0:    o_merged_word[7:0]   = i_store_data[7:0];
                    2'd1:    o_merged_word[15:8]  = i_store_data[7:0];
                    2'd2:    o_merged_word[23:16] = i_store_data[7:0];
                    default: o_merged_word[31:24] = i_store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) begin
                    o_merged_word[31:16] = i_store_data[15:0];
                end else begin
                    o_merged_word[15:0] = i_store_data[15:0];
                end
            end
            SZ_WORD: o_merged_word = i_store_data;
            default: o_merged_word = i_old_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the dmem port. One access in flight at a time;
// sub-word stores are done as read-modify-write of the containing word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; req_ready high
// ST_READ  | dmem_addr driven, word captured at the closing edge
// ST_WRITE | dmem_we high for this one cycle, merged or full word out
// ST_RESP  | resp_valid pulse, result/error presented
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int n = 32,
    parameter int r = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    output logic         resp_err,
    output logic [n-1:0] resp_rdata,
    output logic         dmem_we,
    output logic [n-1:0] dmem_addr,
    output logic [n-1:0] dmem_wdata,
    input  logic [n-1:0] dmem_rdata
);

    state_t       r_state;
    state_t       w_state_nxt;

    logic         r_write;
    logic [1:0]   r_size;
    logic         r_signed;
    logic [1:0]   r_addr_lo;
    logic [n-1:0] r_wdata;
    logic [n-1:0] r_word;
    logic [n-1:0] r_dmem_addr;
    logic         r_err;

    logic         w_accept;
    logic         w_range_err;
    logic         w_req_err;
    logic [n-1:0] w_load_data;
    logic [n-1:0] w_merged_word;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_range_err = |req_addr[n-1:r+2];
    assign w_req_err   = (req_size == 2'b11) || is_misaligned(req_size, req_addr[1:0]) || w_range_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; errors skip the memory entirely, word stores skip the read.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_nxt = ST_RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  w_state_nxt = r_write ? ST_WRITE : ST_RESP;
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture at accept, and the read word at the end of ST_READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_wdata     <= '0;
            r_word      <= '0;
            r_dmem_addr <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write   <= req_write;
                r_size    <= req_size;
                r_signed  <= req_signed;
                r_addr_lo <= req_addr[1:0];
                r_wdata   <= req_wdata;
                r_err     <= w_req_err;
                // An erroring access leaves the dmem index where it was.
                if (!w_req_err) begin
                    r_dmem_addr <= {{(n-r){1'b0}}, req_addr[r+1:2]};
                end
            end
            if (r_state == ST_READ) begin
                r_word <= dmem_rdata;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .i_size        (r_size),
        .i_signed      (r_signed),
        .i_addr_lo     (r_addr_lo),
        .i_old_word    (r_word),
        .i_store_data  (r_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    // Outputs depend only on state and captured registers, never on req_*.
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
        resp_err   = (r_state == ST_RESP) && r_err;
        resp_rdata = ((r_state == ST_RESP) && !r_write && !r_err) ? w_load_data : '0;
        dmem_we    = (r_state == ST_WRITE);
        dmem_addr  = r_dmem_addr;
        dmem_wdata = w_merged_word;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that acts as the initiator on the data-memory port. It accepts one byte, halfword or word access at a time from the core over a valid/ready request channel. It converts the byte address to a dmem word index, performs sub-word stores as read-modify-write, and returns load data or an error on a one-cycle response pulse. It sits between the datapath and `dmem`, and is the only block that drives `dmem`'s `write_enable`, `addr` and `writedata`.

## Interface
- `n`, 32: data and address width.
- `r`, 6: dmem index width; 2**r words are addressable.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `req_valid` in 1: core request present.
- `req_ready` out 1: LSU can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- `req_signed` in 1: sign-extend sub-word loads.
- `req_addr` in n: byte address.
- `req_wdata` in n: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: qualified by `resp_valid`; misaligned, out of range, or illegal size.
- `resp_rdata` out n: load result, qualified by `resp_valid`; 0 for stores and errors.
- `dmem_we` out 1: to dmem `write_enable`.
- `dmem_addr` out n: word index, equal to `req_addr[r+1:2]` zero-extended.
- `dmem_wdata` out n: to dmem `writedata`.
- `dmem_rdata` in n: from dmem `readdata`.

## Operation
- dmem contract:
  - read is combinational from `addr`;
  - write happens at the `clk` rising edge when `write_enable` is 1.
- Request capture: on an edge with `req_valid & req_ready`, register `write`, `size`, `signed`, `addr` and `wdata`. Later changes on the request inputs are ignored.
- Error check at accept time. The access is an error if any of these hold:
  - `size` = 11;
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - `addr[n-1:r+2]` ≠ 0.
- An error access makes no dmem access and goes straight to RESP with `resp_err` = 1.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE → READ for a load or a sub-word store.
  - IDLE → WRITE for a word store.
  - IDLE → RESP on error.
  - READ → RESP for a load.
  - READ → WRITE for a store.
  - WRITE → RESP.
  - RESP → IDLE, unconditionally.
- READ: drive `dmem_addr`; capture `dmem_rdata` into the word register at the closing edge.
- WRITE: `dmem_we` = 1 for exactly one cycle; `dmem_addr` is held.
  - `dmem_wdata` for a word store is `wdata`.
  - `dmem_wdata` for a sub-word store is the captured word with the selected lane(s) replaced.
- Byte lanes are little-endian: byte k is bits [8k+7:8k], selected by `addr[1:0]`; a half is selected by `addr[1]`.
- Load extract: shift the selected lane down, then zero-extend, or sign-extend when `req_signed` = 1. A word load returns the word unchanged.
- `dmem_addr` holds its last value outside READ/WRITE. `dmem_we` is 0 in every state except WRITE.
- No backpressure on the response: `resp_valid` is a pulse the core must sample.

## Timing
- Reset (async, takes effect immediately): state IDLE. `req_ready` = 1; `resp_valid`, `resp_err`, `dmem_we` = 0; `resp_rdata`, `dmem_addr`, `dmem_wdata` = 0.
- Reset mid-operation: the access is aborted with no response. A WRITE interrupted by reset before its edge does not write.
- Latency, counted as accept edge to the edge that begins `resp_valid`:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back throughput: a new request can be accepted in the cycle after RESP, because `req_ready` rises on RESP → IDLE. `req_ready` is therefore low during RESP.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to any output.

## Structure
- Package `dmem_lsu_pkg` holds:
  - the `size_t` enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the `state_t` enum;
  - the function `is_misaligned(size, addr_lo)`.
- Sub-module `lsu_lane_align` is purely combinational. It takes size, signed, `addr[1:0]`, old word and store data, and produces `load_data` and `merged_word`.
- The FSM, capture registers and dmem drive live in `dmem_lsu`.

## Test plan
Bench instantiates `dmem_lsu`, the existing `dmem` and `clock`.
- Word store 0xDEADBEEF at 0x00, then word load at 0x00:
  - store: `dmem_we` is high 1 cycle at index 0; `resp_valid` at +2 with `err` = 0;
  - load: `resp_rdata` = 0xDEADBEEF.
- Byte store 0x55 at 0x02 over 0xDEADBEEF: READ then WRITE, `dmem_wdata` = 0xDE55BEEF, response at +3.
- Byte loads at 0x03:
  - signed: 0xFFFFFFDE;
  - unsigned: 0x000000DE;
  - signed half at 0x00: 0xFFFFBEEF.
- Error cases, each giving `resp_err` = 1 at +1, `dmem_we` never asserted, `resp_rdata` = 0:
  - half at 0x01;
  - word at 0x02;
  - word at 0x100 (beyond 64 words);
  - `size` = 11.
- Reset deasserted... asserted in the WRITE cycle of a byte store to 0x04:
  - `dmem_we` drops immediately and no response is produced;
  - word 1 keeps its prior value 0x0000FFFF;
  - `req_ready` = 1 after release.
- Back-to-back: hold `req_valid` with four alternating store/load requests. Each is accepted exactly one cycle after the previous `resp_valid`, and data matches.
